seg_word_decoder: RTL and testbench
===================================

# seg_word_decoder

Receiver-side decoder for the checkout display path. It accepts the four active-low 7-segment digit patterns of a product word, one digit per handshake and most-significant digit (HEX3) first, from the multiplexed segment bus. It matches the assembled frame against the six product words and returns the 3-bit item code, the discount flag and an error flag through a valid/ready output. It sits between the segment bus tap and the register-check logic.

## Interface
- `ERR_W`, default 8: width of the error counter (used only with the macro).
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `seg_in` in 7: active-low segment pattern, bit 6 = g … bit 0 = a; all-ones = blank.
- `seg_first` in 1: qualifies `seg_in` as HEX3, the first digit of a frame.
- `seg_valid` in 1: digit present.
- `seg_ready` out 1: decoder accepts a digit. Transfer occurs when `seg_valid & seg_ready`.
- `code` out 3: decoded item code.
- `discount` out 1: high when `code` has exactly two bits set (011, 101, 110).
- `bad_word` out 1: the frame matched no product word; `code`=000 and `discount`=0.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result.
- `err_count` out `ERR_W`: saturating count of bad frames.

## Operation
- Word table (HEX3..HEX0):
  - 000 blank,B,A,G = 1111111,0000000,0001000,1000010
  - 001 blank,U,S,B = 1111111,1000001,0010010,0000000
  - 011 D,I,C,E = 1000000,1111001,1000110,0000110
  - 100 B,A,L,L = 0000000,0001000,1000111,1000111
  - 101 blank,C,A,L = 1111111,1000110,0001000,1000111
  - 110 S,O,U,P = 0010010,1000000,1000001,0001100
  - Code 010 and code 111 have no word. The decoder never outputs them with `bad_word`=0.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE: `seg_ready`=1. A digit with `seg_first`=0 is accepted and discarded. A digit with `seg_first`=1 is stored in slot 3, sets idx=2 and moves to COLLECT.
  - COLLECT: `seg_ready`=1.
    - Each accepted digit with `seg_first`=0 goes into slot idx, then idx decrements.
    - An accepted digit with `seg_first`=1 restarts the frame: it overwrites slot 3, sets idx=2 and stays in COLLECT. The partial frame is dropped with no error.
    - Acceptance at idx=0 compares all 4 slots against the table. The match result is registered into `code`/`discount`/`bad_word`, and the FSM moves to HOLD.
  - HOLD: `seg_ready`=0 and `out_valid`=1. Outputs stay stable until `out_ready`=1. On the next edge the FSM returns to IDLE and `out_valid` falls.
- The comparison is exact on all 7 bits. D and O share a pattern; position in the frame disambiguates them.

## Timing
- Reset values: `seg_ready`=0 while `reset_n`=0 and 1 from the first edge after release (FSM in IDLE). `out_valid`=0, `code`=000, `discount`=0, `bad_word`=0, `err_count`=0, idx=0, slots all-ones.
- Latency: `out_valid` rises on the edge that accepts the 4th digit, i.e. it is visible in the following cycle.
- Throughput: with `out_ready` held high, HOLD lasts 1 cycle, so a new frame can start 1 cycle after the result. Best case is 5 cycles per frame.
- `out_ready` is ignored outside HOLD. `seg_ready` does not depend on `seg_valid`.
- Asserting `reset_n` low mid-frame or in HOLD immediately clears everything to reset values; the partial frame and any pending result are lost.

## Configuration
- `SEG_DEC_ERR_CNT_EN` defined:
  - `err_count` increments on the edge that registers `bad_word`=1.
  - It saturates at 2^`ERR_W`−1.
  - It clears only on reset.
- Not defined: `err_count` is tied to 0 and no counter flops are generated. `bad_word` behaves identically either way.

## Structure
- Package `seg_word_pkg`:
  - typedef `seg_t` (logic [6:0]);
  - typedef `item_code_t` (logic [2:0]);
  - blank and letter pattern constants (`SEG_BLANK`, `SEG_A`, `SEG_B`, …);
  - the six-entry word table as a constant array of {code, 4×`seg_t`}.
- One sub-module, `seg_word_match`: purely combinational. Inputs are 4×`seg_t`; outputs are `code`, `hit` and `discount`. The top-level module holds the FSM, slots, idx, output registers and the counter.

## Test plan
- Reset, then frame S,O,U,P (0010010,1000000,1000001,0001100) with `out_ready`=1 → one cycle later `out_valid`=1, `code`=110, `discount`=1, `bad_word`=0. `seg_ready` returns to 1 the following cycle.
- Frame blank,U,S,B with `out_ready`=0 for 5 cycles → outputs hold `code`=001, `discount`=0. `seg_ready`=0 throughout; `seg_valid` digits offered during HOLD are not consumed.
- Frame D,I,C,O (last digit 1000000) → `bad_word`=1, `code`=000. With the macro defined, `err_count` goes 0→1; repeating 300 times gives `err_count`=255 for `ERR_W`=8.
- Send B,A then a new `seg_first` digit, followed by blank,C,A,L → exactly one result, `code`=101, `discount`=1, no error.
- Send two stray digits with `seg_first`=0 in IDLE, then B,A,L,L → the stray digits are discarded and the result is `code`=100, `discount`=0.
- Drop `reset_n` after 2 digits of BAG and release it → `out_valid` stays 0. A following full BAG frame gives `code`=000 and `bad_word`=0.

Source files
------------

// File: rtl/seg_word_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_word_pkg
// Description : Segment pattern types, letter constants and product word table
//               shared by the segment word decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_word_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [2:0] item_code_t;

    // Active-low patterns, bit 6 = g ... bit 0 = a
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000000;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b1000000;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_G     = 7'b1000010;
    localparam seg_t SEG_I     = 7'b1111001;
    localparam seg_t SEG_L     = 7'b1000111;
    localparam seg_t SEG_O     = 7'b1000000;
    localparam seg_t SEG_P     = 7'b0001100;
    localparam seg_t SEG_S     = 7'b0010010;
    localparam seg_t SEG_U     = 7'b1000001;

    typedef struct packed {
        item_code_t      code;
        seg_t [3:0]      digits;   // [3] = HEX3 (first on the bus)
    } word_entry_t;

    localparam int NUM_WORDS = 6;

    localparam word_entry_t [NUM_WORDS-1:0] WORD_TABLE = {
        {3'b110, SEG_S,     SEG_O, SEG_U, SEG_P},
        {3'b101, SEG_BLANK, SEG_C, SEG_A, SEG_L},
        {3'b100, SEG_B,     SEG_A, SEG_L, SEG_L},
        {3'b011, SEG_D,     SEG_I, SEG_C, SEG_E},
        {3'b001, SEG_BLANK, SEG_U, SEG_S, SEG_B},
        {3'b000, SEG_BLANK, SEG_B, SEG_A, SEG_G}
    };

    function automatic logic is_discount(input item_code_t c);
        return ($countones(c) == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_word_match.sv
`default_nettype none
// ============================================================================
// Module      : seg_word_match
// Description : Combinational exact match of a 4-digit frame against the
//               product word table.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_word_match
    import seg_word_pkg::*;
(
    input  logic [3:0][6:0] digits,
    output logic [2:0]      code,
    output logic            hit,
    output logic            discount
);

    always_comb begin
        code = 3'b000;
        hit  = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (digits == WORD_TABLE[i].digits) begin
                code = WORD_TABLE[i].code;
                hit  = 1'b1;
            end
        end
    end

    assign discount = hit & is_discount(code);

endmodule
`default_nettype wire

// File: rtl/seg_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_word_decoder
// Description : Collects four 7-segment digits per frame (HEX3 first), matches
//               them against the product words and presents code/discount/
//               bad_word through a valid/ready output.
//               Optional bad-frame counter: define SEG_DEC_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_word_decoder
    import seg_word_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       seg_in,
    input  logic             seg_first,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic [2:0]       code,
    output logic             discount,
    output logic             bad_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][6:0] slot_q, slot_d;
    logic [2:0]      code_q, code_d;
    logic            discount_q, discount_d;
    logic            bad_word_q, bad_word_d;
    logic            seg_ready_q, seg_ready_d;

    logic            accept;
    logic            last_digit;
    logic [2:0]      match_code;
    logic            match_hit;
    logic            match_discount;

    assign accept     = seg_valid & seg_ready_q;
    assign last_digit = accept & (state_q == ST_COLLECT) & ~seg_first & (idx_q == 2'd0);

    // Slot update kept separate so the matcher sees the frame including the
    // digit being accepted this cycle.
    always_comb begin
        slot_d = slot_q;
        if (accept && (state_q != ST_HOLD)) begin
            if (seg_first) begin
                slot_d[3] = seg_in;
            end else if (state_q == ST_COLLECT) begin
                slot_d[idx_q] = seg_in;
            end
        end
    end

    seg_word_match u_match (
        .digits   (slot_d),
        .code     (match_code),
        .hit      (match_hit),
        .discount (match_discount)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        discount_d = discount_q;
        bad_word_d = bad_word_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && seg_first) begin
                    idx_d   = 2'd2;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (seg_first) begin
                        idx_d = 2'd2;
                    end else if (idx_q == 2'd0) begin
                        code_d     = match_hit ? match_code : 3'b000;
                        discount_d = match_discount;
                        bad_word_d = ~match_hit;
                        state_d    = ST_HOLD;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered so ready stays low through reset and rises on the first edge after.
    assign seg_ready_d = (state_d != ST_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            slot_q      <= {4{SEG_BLANK}};
            code_q      <= 3'b000;
            discount_q  <= 1'b0;
            bad_word_q  <= 1'b0;
            seg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            code_q      <= code_d;
            discount_q  <= discount_d;
            bad_word_q  <= bad_word_d;
            seg_ready_q <= seg_ready_d;
        end
    end

    assign seg_ready = seg_ready_q;
    assign out_valid = (state_q == ST_HOLD);
    assign code      = code_q;
    assign discount  = discount_q;
    assign bad_word  = bad_word_q;

`ifdef SEG_DEC_ERR_CNT_EN
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             bad_load;

    assign bad_load = last_digit & ~match_hit;

    always_comb begin
        err_count_d = err_count_q;
        if (bad_load && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_last_digit;
    assign unused_last_digit = last_digit;
    assign err_count         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_word_decoder
// Description : Self-checking bench for seg_word_decoder with a queue-based
//               reference model and directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_word_decoder;

    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [6:0]       seg_in = 7'h7f;
    logic             seg_first = 1'b0;
    logic             seg_valid = 1'b0;
    logic             seg_ready;
    logic [2:0]       code;
    logic             discount;
    logic             bad_word;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ERR_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_res  = 0;
    bit run_cmp = 1'b0;

    seg_word_decoder #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .seg_first (seg_first),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .code      (code),
        .discount  (discount),
        .bad_word  (bad_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Words as 28-bit values, HEX3 in the top seven bits
    localparam logic [27:0] W_BAG  = {7'b1111111, 7'b0000000, 7'b0001000, 7'b1000010};
    localparam logic [27:0] W_USB  = {7'b1111111, 7'b1000001, 7'b0010010, 7'b0000000};
    localparam logic [27:0] W_DICE = {7'b1000000, 7'b1111001, 7'b1000110, 7'b0000110};
    localparam logic [27:0] W_BALL = {7'b0000000, 7'b0001000, 7'b1000111, 7'b1000111};
    localparam logic [27:0] W_CAL  = {7'b1111111, 7'b1000110, 7'b0001000, 7'b1000111};
    localparam logic [27:0] W_SOUP = {7'b0010010, 7'b1000000, 7'b1000001, 7'b0001100};
    localparam logic [27:0] W_DICO = {7'b1000000, 7'b1111001, 7'b1000110, 7'b1000000};

    // Returns the item code of a product word, or -1 when it is not one
    function automatic int lookup(input logic [27:0] w);
        case (w)
            W_BAG:   return 0;
            W_USB:   return 1;
            W_DICE:  return 3;
            W_BALL:  return 4;
            W_CAL:   return 5;
            W_SOUP:  return 6;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [6:0]  mq[$];
    logic        m_ready = 1'b0;
    logic        m_hold  = 1'b0;
    logic [2:0]  m_code  = 3'b000;
    logic        m_disc  = 1'b0;
    logic        m_bad   = 1'b0;
    logic [7:0]  m_err   = 8'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ready <= 1'b0;
            m_hold  <= 1'b0;
            m_code  <= 3'b000;
            m_disc  <= 1'b0;
            m_bad   <= 1'b0;
            m_err   <= 8'd0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold  <= 1'b0;
                m_ready <= 1'b1;
            end
        end else begin
            m_ready <= 1'b1;
            if (seg_valid && m_ready) begin
                if (seg_first) begin
                    mq.delete();
                    mq.push_back(seg_in);
                end else if (mq.size() != 0) begin
                    mq.push_back(seg_in);
                    if (mq.size() == 4) begin
                        if (lookup({mq[0], mq[1], mq[2], mq[3]}) < 0) begin
                            m_code <= 3'b000;
                            m_disc <= 1'b0;
                            m_bad  <= 1'b1;
`ifdef SEG_DEC_ERR_CNT_EN
                            if (m_err != 8'd255) m_err <= m_err + 8'd1;
`endif
                        end else begin
                            m_code <= 3'(lookup({mq[0], mq[1], mq[2], mq[3]}));
                            m_disc <= ($countones(3'(lookup({mq[0], mq[1], mq[2], mq[3]}))) == 2);
                            m_bad  <= 1'b0;
                        end
                        m_hold  <= 1'b1;
                        m_ready <= 1'b0;
                        mq.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("seg_ready", int'(seg_ready), int'(m_ready));
            chk("out_valid", int'(out_valid), int'(m_hold));
            chk("code",      int'(code),      int'(m_code));
            chk("discount",  int'(discount),  int'(m_disc));
            chk("bad_word",  int'(bad_word),  int'(m_bad));
            chk("err_count", int'(err_count), int'(m_err));
            if (out_valid) n_res++;
        end
    end

    task automatic send(input logic [6:0] d, input logic first);
        bit acc;
        int n;
        seg_in    = d;
        seg_first = first;
        seg_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = seg_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: digit %b not accepted within 50 cycles", d);
        end
        seg_valid = 1'b0;
        seg_first = 1'b0;
    endtask

    task automatic send_frame(input logic [27:0] w);
        send(w[27:21], 1'b1);
        send(w[20:14], 1'b0);
        send(w[13:7],  1'b0);
        send(w[6:0],   1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        run_cmp = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_seg_ready", int'(seg_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err_count", int'(err_count), 0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("post_rst_seg_ready", int'(seg_ready), 1);
        next_cycle();

        // SOUP with out_ready high
        send_frame(W_SOUP);
        @(negedge clk);
        chk("soup_valid", int'(out_valid), 1);
        chk("soup_code",  int'(code), 6);
        chk("soup_disc",  int'(discount), 1);
        chk("soup_bad",   int'(bad_word), 0);
        next_cycle();
        @(negedge clk);
        chk("soup_ready_back", int'(seg_ready), 1);
        chk("soup_valid_fall", int'(out_valid), 0);
        next_cycle();

        // USB with back-pressure, digits offered during HOLD
        out_ready = 1'b0;
        send_frame(W_USB);
        seg_in    = 7'b0010010;
        seg_first = 1'b1;
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("usb_hold_valid", int'(out_valid), 1);
            chk("usb_hold_code",  int'(code), 1);
            chk("usb_hold_ready", int'(seg_ready), 0);
        end
        next_cycle();
        seg_valid = 1'b0;
        seg_first = 1'b0;
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("usb_released", int'(out_valid), 0);
        next_cycle();

        // DICO is not a word
        send_frame(W_DICO);
        @(negedge clk);
        chk("dico_bad",  int'(bad_word), 1);
        chk("dico_code", int'(code), 0);
`ifdef SEG_DEC_ERR_CNT_EN
        chk("dico_err1", int'(err_count), 1);
`else
        chk("dico_err0", int'(err_count), 0);
`endif
        next_cycle();
        for (int i = 0; i < 299; i++) send_frame(W_DICO);
        @(negedge clk);
`ifdef SEG_DEC_ERR_CNT_EN
        chk("dico_err_sat", int'(err_count), 255);
`else
        chk("dico_err_off", int'(err_count), 0);
`endif
        next_cycle();

        // Restart mid-frame: B,A then blank,C,A,L
        next_cycle();
        n_res = 0;
        send(7'b0000000, 1'b1);
        send(7'b0001000, 1'b0);
        send_frame(W_CAL);
        @(negedge clk);
        chk("cal_code", int'(code), 5);
        chk("cal_disc", int'(discount), 1);
        chk("cal_bad",  int'(bad_word), 0);
        repeat (3) next_cycle();
        chk("cal_one_result", n_res, 1);

        // Stray digits in IDLE then BALL
        send(7'b1000111, 1'b0);
        send(7'b0001000, 1'b0);
        send_frame(W_BALL);
        @(negedge clk);
        chk("ball_valid", int'(out_valid), 1);
        chk("ball_code",  int'(code), 4);
        chk("ball_disc",  int'(discount), 0);
        next_cycle();

        // DICE then reset mid-frame of BAG
        send_frame(W_DICE);
        @(negedge clk);
        chk("dice_code", int'(code), 3);
        chk("dice_disc", int'(discount), 1);
        next_cycle();
        send(7'b1111111, 1'b1);
        send(7'b0000000, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(seg_ready), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_code",  int'(code), 0);
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            chk("postrst_valid", int'(out_valid), 0);
        end
        next_cycle();
        send_frame(W_BAG);
        @(negedge clk);
        chk("bag_valid", int'(out_valid), 1);
        chk("bag_code",  int'(code), 0);
        chk("bag_bad",   int'(bad_word), 0);
        chk("bag_err",   int'(err_count), 0);
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
